// File: rtl/fcp_credit_gate.sv
// FCP credit gate: per-VC FCCL/FCCT tables with a grant/deny decision per transmit request.
// Optional statistics counters are enabled with `define FCP_CREDIT_GATE_STATS_EN.
module fcp_credit_gate #(
  parameter int QUEUE_INDEX_WIDTH = 15,
  parameter int STAT_WIDTH        = 32,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fcp_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  input  logic [STAT_WIDTH-1:0]        fcp_fccl,
  input  logic                         s_req_valid,
  output logic                         s_req_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_req_vc,
  input  logic [LEN_WIDTH-1:0]         s_req_blocks,
  output logic                         m_rsp_valid,
  input  logic                         m_rsp_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_rsp_vc,
  output logic                         m_rsp_grant,
  output logic                         init_done
`ifdef FCP_CREDIT_GATE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]        stat_grant_count,
  output logic [STAT_WIDTH-1:0]        stat_deny_count,
  output logic [STAT_WIDTH-1:0]        stat_fcp_drop_count
`endif
);

  localparam int DEPTH = 2 ** QUEUE_INDEX_WIDTH;
  localparam logic [QUEUE_INDEX_WIDTH-1:0] PTR_ONE  = {{(QUEUE_INDEX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [QUEUE_INDEX_WIDTH-1:0] PTR_LAST = {QUEUE_INDEX_WIDTH{1'b1}};
  localparam logic [STAT_WIDTH-1:0]        STAT_ZERO = {STAT_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_EV   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                       state_r;
  state_t                       state_nxt_s;
  logic [QUEUE_INDEX_WIDTH-1:0] init_ptr_r;
  logic [QUEUE_INDEX_WIDTH-1:0] req_vc_r;
  logic [LEN_WIDTH-1:0]         req_blocks_r;
  logic [STAT_WIDTH-1:0]        rd_fccl_r;
  logic [STAT_WIDTH-1:0]        rd_fcct_r;
  logic [STAT_WIDTH-1:0]        fccl_mem_r [DEPTH];
  logic [STAT_WIDTH-1:0]        fcct_mem_r [DEPTH];

  logic                         init_last_s;
  logic                         fcp_hit_s;
  logic [STAT_WIDTH-1:0]        fccl_eff_s;
  logic [STAT_WIDTH-1:0]        blocks_ext_s;
  logic [STAT_WIDTH-1:0]        diff_s;
  logic                         grant_s;
  logic                         fccl_we_s;
  logic [QUEUE_INDEX_WIDTH-1:0] fccl_wa_s;
  logic [STAT_WIDTH-1:0]        fccl_wd_s;
  logic                         fcct_we_s;
  logic [QUEUE_INDEX_WIDTH-1:0] fcct_wa_s;
  logic [STAT_WIDTH-1:0]        fcct_wd_s;

  assign init_last_s  = (init_ptr_r == PTR_LAST);
  assign fcp_hit_s    = fcp_valid && (fcp_vc == req_vc_r);
  assign blocks_ext_s = STAT_WIDTH'(req_blocks_r);

  // Credit evaluation: an FCP update landing in the EV cycle beats the registered read.
  always_comb begin
    fccl_eff_s = rd_fccl_r;
    if (fcp_hit_s) begin
      fccl_eff_s = fcp_fccl;
    end else begin
      fccl_eff_s = rd_fccl_r;
    end
    diff_s  = fccl_eff_s - rd_fcct_r - blocks_ext_s;
    grant_s = ($signed(diff_s) >= $signed(STAT_ZERO));
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_last_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_INIT;
      end
      ST_IDLE: begin
        if (s_req_valid && s_req_ready) state_nxt_s = ST_RD;
        else                            state_nxt_s = ST_IDLE;
      end
      ST_RD:   state_nxt_s = ST_EV;
      ST_EV:   state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (m_rsp_ready) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Table write ports: INIT clears both, otherwise FCP owns FCCL and EV owns FCCT.
  always_comb begin
    fccl_we_s = 1'b0;
    fccl_wa_s = fcp_vc;
    fccl_wd_s = fcp_fccl;
    fcct_we_s = 1'b0;
    fcct_wa_s = req_vc_r;
    fcct_wd_s = rd_fcct_r + blocks_ext_s;
    if (state_r == ST_INIT) begin
      fccl_we_s = 1'b1;
      fccl_wa_s = init_ptr_r;
      fccl_wd_s = STAT_ZERO;
      fcct_we_s = 1'b1;
      fcct_wa_s = init_ptr_r;
      fcct_wd_s = STAT_ZERO;
    end else begin
      fccl_we_s = fcp_valid;
      fcct_we_s = (state_r == ST_EV) && grant_s;
    end
  end

  // Table storage, left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (fccl_we_s) fccl_mem_r[fccl_wa_s] <= fccl_wd_s;
    if (fcct_we_s) fcct_mem_r[fcct_wa_s] <= fcct_wd_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_INIT;
    else     state_r <= state_nxt_s;
  end

  // Init pointer, request latch and table read registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_ptr_r   <= {QUEUE_INDEX_WIDTH{1'b0}};
      req_vc_r     <= {QUEUE_INDEX_WIDTH{1'b0}};
      req_blocks_r <= {LEN_WIDTH{1'b0}};
      rd_fccl_r    <= STAT_ZERO;
      rd_fcct_r    <= STAT_ZERO;
    end else begin
      if (state_r == ST_INIT) init_ptr_r <= init_ptr_r + PTR_ONE;
      if (state_r == ST_IDLE && s_req_valid && s_req_ready) begin
        req_vc_r     <= s_req_vc;
        req_blocks_r <= s_req_blocks;
      end
      if (state_r == ST_RD) begin
        // RAM read would miss a same-cycle FCP write, so forward it here.
        rd_fccl_r <= fcp_hit_s ? fcp_fccl : fccl_mem_r[req_vc_r];
        rd_fcct_r <= fcct_mem_r[req_vc_r];
      end
    end
  end

  // Registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_req_ready <= 1'b0;
      m_rsp_valid <= 1'b0;
      m_rsp_vc    <= {QUEUE_INDEX_WIDTH{1'b0}};
      m_rsp_grant <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      s_req_ready <= (state_nxt_s == ST_IDLE);
      m_rsp_valid <= (state_nxt_s == ST_RESP);
      if (state_r == ST_EV) begin
        m_rsp_vc    <= req_vc_r;
        m_rsp_grant <= grant_s;
      end
      if (state_r == ST_INIT && init_last_s) init_done <= 1'b1;
    end
  end

`ifdef FCP_CREDIT_GATE_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  // Decision and dropped-update statistics, wrapping on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant_count    <= STAT_ZERO;
      stat_deny_count     <= STAT_ZERO;
      stat_fcp_drop_count <= STAT_ZERO;
    end else begin
      if (state_r == ST_EV && grant_s)  stat_grant_count <= stat_grant_count + STAT_ONE;
      if (state_r == ST_EV && !grant_s) stat_deny_count  <= stat_deny_count + STAT_ONE;
      if (state_r == ST_INIT && fcp_valid) stat_fcp_drop_count <= stat_fcp_drop_count + STAT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_fcp_credit_gate.sv
// Self-checking bench for fcp_credit_gate: directed scenarios plus randomized traffic
// checked against a per-VC credit model (16 VCs, 32-bit counters and block counts).
module tb_fcp_credit_gate;

  localparam int QW = 4;
  localparam int SW = 32;
  localparam int LW = 32;
  localparam int NV = 2 ** QW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fcp_valid = 1'b0;
  logic [QW-1:0] fcp_vc = '0;
  logic [SW-1:0] fcp_fccl = '0;
  logic          s_req_valid = 1'b0;
  logic          s_req_ready;
  logic [QW-1:0] s_req_vc = '0;
  logic [LW-1:0] s_req_blocks = '0;
  logic          m_rsp_valid;
  logic          m_rsp_ready = 1'b0;
  logic [QW-1:0] m_rsp_vc;
  logic          m_rsp_grant;
  logic          init_done;
`ifdef FCP_CREDIT_GATE_STATS_EN
  logic [SW-1:0] stat_grant_count;
  logic [SW-1:0] stat_deny_count;
  logic [SW-1:0] stat_fcp_drop_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [SW-1:0] fccl_m [NV];
  logic [SW-1:0] fcct_m [NV];

  fcp_credit_gate #(.QUEUE_INDEX_WIDTH(QW), .STAT_WIDTH(SW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .fcp_valid(fcp_valid), .fcp_vc(fcp_vc), .fcp_fccl(fcp_fccl),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_vc(s_req_vc), .s_req_blocks(s_req_blocks),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_vc(m_rsp_vc), .m_rsp_grant(m_rsp_grant),
    .init_done(init_done)
`ifdef FCP_CREDIT_GATE_STATS_EN
    , .stat_grant_count(stat_grant_count), .stat_deny_count(stat_deny_count),
    .stat_fcp_drop_count(stat_fcp_drop_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < NV; i++) begin
      fccl_m[i] = '0;
      fcct_m[i] = '0;
    end
  endfunction

  // One cycle of FCP traffic starting at a negedge; the model sees the new limit immediately.
  task automatic fcp_cycle(input bit fv, input logic [QW-1:0] vc, input logic [SW-1:0] val);
    fcp_valid = fv;
    fcp_vc    = vc;
    fcp_fccl  = val;
    if (fv) fccl_m[vc] = val;
    @(negedge clk);
    fcp_valid = 1'b0;
  endtask

  // Issue one request, optionally with FCP updates in the RD and EV cycles, then hold and consume.
  task automatic do_req(input logic [QW-1:0] vc, input logic [LW-1:0] blk,
                        input bit rd_fv, input logic [QW-1:0] rd_vc, input logic [SW-1:0] rd_val,
                        input bit ev_fv, input logic [QW-1:0] ev_vc, input logic [SW-1:0] ev_val,
                        input int hold, input string name);
    int waitc;
    logic [SW-1:0] diff;
    bit exp_g;
    waitc = 0;
    while (s_req_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    n_chk++;
    if (s_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: s_req_ready=%b required 1", name, s_req_ready);
      return;
    end
    s_req_valid  = 1'b1;
    s_req_vc     = vc;
    s_req_blocks = blk;
    @(negedge clk);
    s_req_valid = 1'b0;
    n_chk++;
    if (s_req_ready !== 1'b0 || m_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rd_cycle: ready=%b valid=%b required 0 0", name, s_req_ready, m_rsp_valid);
    end
    fcp_cycle(rd_fv, rd_vc, rd_val);
    fcp_cycle(ev_fv, ev_vc, ev_val);
    diff  = fccl_m[vc] - fcct_m[vc] - blk;
    exp_g = ($signed(diff) >= 0);
    n_chk++;
    if (m_rsp_valid !== 1'b1 || m_rsp_vc !== vc || m_rsp_grant !== exp_g) begin
      n_fail++;
      $display("FAIL %s response: valid=%b vc=%0d grant=%b required 1 %0d %b",
               name, m_rsp_valid, m_rsp_vc, m_rsp_grant, vc, exp_g);
    end
    if (exp_g) fcct_m[vc] = fcct_m[vc] + blk;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++;
      if (m_rsp_valid !== 1'b1 || m_rsp_vc !== vc || m_rsp_grant !== exp_g || s_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b vc=%0d grant=%b ready=%b required 1 %0d %b 0",
                 name, i, m_rsp_valid, m_rsp_vc, m_rsp_grant, s_req_ready, vc, exp_g);
      end
    end
    m_rsp_ready = 1'b1;
    @(negedge clk);
    m_rsp_ready = 1'b0;
    n_chk++;
    if (m_rsp_valid !== 1'b0 || s_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: valid=%b ready=%b required 0 1", name, m_rsp_valid, s_req_ready);
    end
  endtask

  task automatic test_reset();
    int cnt;
    model_clear();
    repeat (3) @(negedge clk);
    n_chk++;
    if (s_req_ready !== 1'b0 || m_rsp_valid !== 1'b0 || m_rsp_vc !== '0 ||
        m_rsp_grant !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b vc=%0d grant=%b init_done=%b required all 0",
               s_req_ready, m_rsp_valid, m_rsp_vc, m_rsp_grant, init_done);
    end
    rst = 1'b0;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_chk++;
    if (cnt != NV || s_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_time: cycles=%0d ready=%b required %0d 1", cnt, s_req_ready, NV);
    end
    @(negedge clk);
    do_req(4'd3, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "no_credit_vc3");
  endtask

  task automatic test_basic_credit();
    fcp_cycle(1'b1, 4'd5, 32'd100);
    do_req(4'd5, 32'd60, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "vc5_blk60");
    do_req(4'd5, 32'd41, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "vc5_blk41");
    do_req(4'd5, 32'd40, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "vc5_blk40");
    do_req(4'd5, 32'd0,  1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "vc5_zero_at_limit");
    fcp_cycle(1'b1, 4'd5, 32'd99);
    do_req(4'd5, 32'd0,  1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "vc5_zero_below");
  endtask

  task automatic test_forwarding();
    fcp_cycle(1'b1, 4'd2, 32'd10);
    do_req(4'd2, 32'd20, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'd30, 0, "fwd_ev_vc2");
    fcp_cycle(1'b1, 4'd4, 32'd5);
    do_req(4'd4, 32'd8, 1'b1, 4'd4, 32'd8, 1'b0, 4'd0, 32'd0, 0, "fwd_rd_vc4");
    do_req(4'd4, 32'd1, 1'b1, 4'd4, 32'd100, 1'b1, 4'd4, 32'd8, 0, "fwd_ev_beats_rd");
  endtask

  task automatic test_wrap();
    fcp_cycle(1'b1, 4'd7, 32'hFFFF_FFF0);
    do_req(4'd7, 32'hFFFF_FFF0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "wrap_fill");
    fcp_cycle(1'b1, 4'd7, 32'h0000_0010);
    do_req(4'd7, 32'h20, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "wrap_cross");
    do_req(4'd7, 32'h0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "wrap_at_limit");
    fcp_cycle(1'b1, 4'd7, 32'h0000_000F);
    do_req(4'd7, 32'h0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "wrap_below");
  endtask

  task automatic test_backpressure();
    fcp_cycle(1'b1, 4'd9, 32'd50);
    do_req(4'd9, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5, "hold_grant");
    do_req(4'd9, 32'd44, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 5, "hold_deny");
  endtask

  task automatic test_random();
    logic [QW-1:0] vc;
    logic [QW-1:0] rvc;
    logic [QW-1:0] evc;
    logic [LW-1:0] blk;
    for (int n = 0; n < 60; n++) begin
      vc  = QW'($urandom_range(0, NV - 1));
      blk = LW'($urandom_range(0, 20));
      rvc = ($urandom_range(0, 1) == 0) ? vc : QW'($urandom_range(0, NV - 1));
      evc = ($urandom_range(0, 1) == 0) ? vc : QW'($urandom_range(0, NV - 1));
      if ($urandom_range(0, 1) == 1)
        fcp_cycle(1'b1, vc, fcct_m[vc] + SW'($urandom_range(0, 40)) - 32'd20);
      do_req(vc, blk,
             ($urandom_range(0, 2) == 0), rvc, fcct_m[rvc] + SW'($urandom_range(0, 40)) - 32'd20,
             ($urandom_range(0, 2) == 0), evc, fcct_m[evc] + SW'($urandom_range(0, 40)) - 32'd20,
             int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_reset_in_resp();
    int cnt;
    fcp_cycle(1'b1, 4'd1, 32'd20);
    s_req_valid  = 1'b1;
    s_req_vc     = 4'd1;
    s_req_blocks = 32'd3;
    @(negedge clk);
    s_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (m_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_resp_pre: valid=%b required 1", m_rsp_valid);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (m_rsp_valid !== 1'b0 || s_req_ready !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resp_drop: valid=%b ready=%b init_done=%b required 0 0 0",
               m_rsp_valid, s_req_ready, init_done);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    fcp_valid = 1'b1;
    fcp_vc    = 4'd9;
    fcp_fccl  = 32'd500;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 3) fcp_valid = 1'b0;
    end
    fcp_valid = 1'b0;
    n_chk++;
    if (cnt != NV) begin
      n_fail++;
      $display("FAIL reinit_time: cycles=%0d required %0d", cnt, NV);
    end
    @(negedge clk);
    for (int v = 0; v < NV; v++)
      do_req(QW'(v), 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 0, "post_reinit_deny");
  endtask

  initial begin
    test_reset();
    test_basic_credit();
    test_forwarding();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fcp_credit_gate.md
Name: fcp_credit_gate

Overview:
- Sits directly downstream of the FCP sink adapter and consumes its discrete FCP update stream (valid/vc/fccl).
- Keeps a per-VC table of the latest advertised credit limit (FCCL) and a per-VC count of blocks already transmitted (FCCT).
- Arbitrates transmit requests from the scheduler with a grant/deny decision. On grant, FCCT for that VC advances by the request size.
- Enforces FCP credit so that a VC never sends past the limit the receiver advertised.

Parameters:
- QUEUE_INDEX_WIDTH, 15, VC index width; table depth = 2**QUEUE_INDEX_WIDTH.
- STAT_WIDTH, 32, width of FCCL/FCCT counters (modular).
- LEN_WIDTH, 16, width of request block count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fcp_valid  in  1  FCP update strobe, one update per cycle, no backpressure
- fcp_vc  in  QUEUE_INDEX_WIDTH  VC of update
- fcp_fccl  in  STAT_WIDTH  new credit limit for fcp_vc
- s_req_valid  in  1  transmit request valid
- s_req_ready  out  1  request accepted when valid&&ready
- s_req_vc  in  QUEUE_INDEX_WIDTH  requesting VC
- s_req_blocks  in  LEN_WIDTH  blocks the request would consume
- m_rsp_valid  out  1  decision valid
- m_rsp_ready  in  1  decision consumed when valid&&ready
- m_rsp_vc  out  QUEUE_INDEX_WIDTH  VC of decision
- m_rsp_grant  out  1  1 = granted (FCCT advanced), 0 = denied
- init_done  out  1  table clear complete

Behaviour:
- Reset (async assert, sync release): s_req_ready=0, m_rsp_valid=0, m_rsp_vc=0, m_rsp_grant=0, init_done=0, FSM=INIT, init pointer=0.
- INIT: one entry per cycle, write FCCL=0 and FCCT=0 at pointer. After entry 2**QUEUE_INDEX_WIDTH-1 is written, set init_done=1 and go to IDLE. FCP updates arriving during INIT are discarded.
- Reset mid-operation: tables are not trusted; INIT reruns in full and any in-flight response is dropped.
- FCCL write: outside INIT, every fcp_valid cycle writes fcp_fccl to FCCL[fcp_vc] unconditionally; the last value wins, with no monotonic check.
- IDLE: s_req_ready=1. On handshake, latch vc/blocks and go to RD.
- RD: issue table reads for the latched vc, s_req_ready=0. Go to EV.
- EV: diff = FCCL - FCCT - blocks (zero-extended), mod 2**STAT_WIDTH.
  - grant = MSB of diff == 0, i.e. a signed non-negative result.
  - On grant, FCCT[vc] <= FCCT[vc] + blocks (wraps mod 2**STAT_WIDTH).
  - Set m_rsp_valid=1, m_rsp_vc, m_rsp_grant; go to RESP.
- RESP: hold m_rsp_* stable until m_rsp_ready. On that handshake cycle drop m_rsp_valid and go to IDLE; s_req_ready rises on the following cycle.
- Latency: request handshake at cycle T gives m_rsp_valid at T+3. Max throughput is one request per 4 cycles.
- FCCL forwarding: an fcp_valid with fcp_vc == latched vc in the RD or EV cycle must be reflected in the EV comparison. The update in the EV cycle itself takes precedence over the RAM read value.
- blocks=0: grants iff FCCL-FCCT is non-negative; FCCT is unchanged.
- Denial never modifies FCCT.
- Wrap-around: the modular compare stays correct across 2**STAT_WIDTH wrap while FCCL-FCCT < 2**(STAT_WIDTH-1).
- FCCL/FCCT are single-port-read/single-port-write RAMs (FCCL write port owned by FCP, FCCT write port owned by EV). INIT owns both write ports exclusively.

Optional Feature:
- Macro FCP_CREDIT_GATE_STATS_EN.
- When defined, adds outputs stat_grant_count and stat_deny_count (both STAT_WIDTH, wrap on overflow, reset to 0), and stat_fcp_drop_count (STAT_WIDTH, counts FCP updates discarded during INIT, reset to 0).
- Each grant/deny counter increments on the cycle EV decides.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- QUEUE_INDEX_WIDTH=4: release reset -> init_done rises after exactly 16 cycles. A request for vc 3, blocks 1 before any FCP -> grant=0.
- FCP vc 5 fccl=100; request vc 5 blocks 60 -> grant=1. Request vc 5 blocks 41 -> grant=0. Request vc 5 blocks 40 -> grant=1; FCCT[5]=100.
- FCP vc 2 fccl=10; request vc 2 blocks 20 accepted; FCP vc 2 fccl=30 in the EV cycle -> grant=1.
- FCCT[7] driven to 0xFFFFFFF0 via grants; FCP vc 7 fccl=0x00000010; request blocks 0x20 -> grant=1, FCCT wraps to 0x00000010.
- Hold m_rsp_ready=0 for 5 cycles -> m_rsp_* stable, s_req_ready=0 throughout. Release -> s_req_ready=1 the next cycle.
- Assert rst during RESP -> m_rsp_valid=0 immediately, INIT reruns, and FCCL of all VCs reads 0 afterwards (a request with blocks 1 is denied).
